// File: rtl/cpu_pkg.sv
// Shared CPU widths and the write-back queue entry payload.
package cpu_pkg;

   localparam int unsigned WBQ_DEPTH = 4;
   localparam int unsigned ADDR_W    = 5;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned CNT_W     = 3;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// Youngest-match search over the queued register writes, walking from head (oldest) to tail.
module wbq_fwd_match
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = WBQ_DEPTH
) (
   input  wb_entry_t                  i_ent [DEPTH],
   input  logic [DEPTH-1:0]           i_vld,
   input  logic [$clog2(DEPTH)-1:0]   i_head,
   input  logic [ADDR_W-1:0]          i_q,
   output logic                       o_hit_c,
   output logic [DATA_W-1:0]          o_data_c
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW-1:0] w_idx;

   // Later (younger) matches overwrite earlier ones; register 0 never forwards.
   always_comb begin
      o_hit_c  = 1'b0;
      o_data_c = '0;
      w_idx    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = i_head + PW'(k);
         if ((i_q != '0) && i_vld[w_idx] && (i_ent[w_idx].addr == i_q)) begin
            o_hit_c  = 1'b1;
            o_data_c = i_ent[w_idx].data;
         end
      end
   end

endmodule

// File: rtl/wb_queue.sv
// Register-file write-back queue: two writers (A older than B), one write per cycle out, forwarding lookup.
module wb_queue
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = WBQ_DEPTH
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              AValid,
   input  logic [ADDR_W-1:0] AAddr,
   input  logic [DATA_W-1:0] AData,
   output logic              AReady,
   input  logic              BValid,
   input  logic [ADDR_W-1:0] BAddr,
   input  logic [DATA_W-1:0] BData,
   output logic              BReady,
   output logic [ADDR_W-1:0] A3,
   output logic [DATA_W-1:0] Wd,
   output logic              We,
   input  logic [ADDR_W-1:0] Q1,
   input  logic [ADDR_W-1:0] Q2,
   output logic              Hit1,
   output logic [DATA_W-1:0] Fd1,
   output logic              Hit2,
   output logic [DATA_W-1:0] Fd2,
   output logic [CNT_W-1:0]  Count,
   output logic              Empty,
   output logic              Full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   wb_entry_t        r_ent [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [CW-1:0]    r_count;

   logic [CW-1:0]    w_free;
   logic             w_a_enq;
   logic             w_b_enq;
   logic             w_deq;
   logic [PW-1:0]    w_b_slot;
   logic [DEPTH-1:0] w_vld_nxt;

   // Free space ignores the same-cycle dequeue so a full queue never enqueues and dequeues together.
   assign w_free   = CW'(DEPTH) - r_count;
   assign AReady   = (w_free >= CW'(1));
   assign BReady   = AValid ? (w_free >= CW'(2)) : (w_free >= CW'(1));

   // Writes to register 0 are acknowledged but dropped.
   assign w_a_enq  = AValid && AReady && (AAddr != '0);
   assign w_b_enq  = BValid && BReady && (BAddr != '0);
   assign w_deq    = (r_count != '0);
   assign w_b_slot = r_tail + PW'(w_a_enq);

   always_comb begin
      w_vld_nxt = r_vld;
      if (w_deq)   w_vld_nxt[r_head]   = 1'b0;
      if (w_a_enq) w_vld_nxt[r_tail]   = 1'b1;
      if (w_b_enq) w_vld_nxt[w_b_slot] = 1'b1;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_vld   <= '0;
      end else begin
         r_head  <= r_head + PW'(w_deq);
         r_tail  <= r_tail + PW'(w_a_enq) + PW'(w_b_enq);
         r_count <= r_count + CW'(w_a_enq) + CW'(w_b_enq) - CW'(w_deq);
         r_vld   <= w_vld_nxt;
      end
   end

   // Payload storage needs no reset; validity is tracked separately.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         if (w_a_enq) r_ent[r_tail]   <= {AAddr, AData};
         if (w_b_enq) r_ent[w_b_slot] <= {BAddr, BData};
      end
   end

   assign We    = w_deq;
   assign A3    = w_deq ? r_ent[r_head].addr : '0;
   assign Wd    = w_deq ? r_ent[r_head].data : '0;
   assign Empty = (r_count == '0);
   assign Full  = (r_count == CW'(DEPTH));
   assign Count = CNT_W'(r_count);

   wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
      .i_ent    (r_ent),
      .i_vld    (r_vld),
      .i_head   (r_head),
      .i_q      (Q1),
      .o_hit_c  (Hit1),
      .o_data_c (Fd1)
   );

   wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
      .i_ent    (r_ent),
      .i_vld    (r_vld),
      .i_head   (r_head),
      .i_q      (Q2),
      .o_hit_c  (Hit2),
      .o_data_c (Fd2)
   );

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed vector table, then a queue-model scoreboard for random, wrap and reset traffic.
module tb_wb_queue;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        AValid, BValid;
   logic [4:0]  AAddr, BAddr, Q1, Q2, A3;
   logic [31:0] AData, BData, Wd, Fd1, Fd2;
   logic        AReady, BReady, We, Hit1, Hit2, Empty, Full;
   logic [2:0]  Count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 Clk = ~Clk;

   wb_queue dut (
      .Clk(Clk), .Reset(Reset),
      .AValid(AValid), .AAddr(AAddr), .AData(AData), .AReady(AReady),
      .BValid(BValid), .BAddr(BAddr), .BData(BData), .BReady(BReady),
      .A3(A3), .Wd(Wd), .We(We),
      .Q1(Q1), .Q2(Q2),
      .Hit1(Hit1), .Fd1(Fd1), .Hit2(Hit2), .Fd2(Fd2),
      .Count(Count), .Empty(Empty), .Full(Full)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                        input logic [4:0] q1, input logic [4:0] q2);
      Reset = rst; AValid = av; AAddr = aa; AData = ad;
      BValid = bv; BAddr = ba; BData = bd; Q1 = q1; Q2 = q2;
   endtask

   // Directed vectors: inputs for one cycle and the outputs expected during that cycle.
   typedef struct {
      logic        av; logic [4:0] aa; logic [31:0] ad;
      logic        bv; logic [4:0] ba; logic [31:0] bd;
      logic [4:0]  q1;
      logic        we; logic [4:0] a3; logic [31:0] wd; logic [2:0] cnt;
      logic        ar; logic br; logic h1; logic [31:0] f1;
   } vec_t;

   localparam int NV = 17;
   vec_t tbl [NV];

   typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
   ent_t mq [$];

   // One cycle against the reference queue; expected writes are popped as the DUT retires them.
   task automatic cyc(input logic rst, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic [4:0] q1, input logic [4:0] q2);
      int  fr;
      logic ear, ebr, h1, h2;
      logic [31:0] f1, f2;
      drive(rst, av, aa, ad, bv, ba, bd, q1, q2);
      @(negedge Clk);
      fr  = 4 - mq.size();
      ear = (fr >= 1);
      ebr = av ? (fr >= 2) : (fr >= 1);
      h1 = 1'b0; h2 = 1'b0; f1 = '0; f2 = '0;
      foreach (mq[i]) begin
         if (q1 != 0 && mq[i].a == q1) begin h1 = 1'b1; f1 = mq[i].d; end
         if (q2 != 0 && mq[i].a == q2) begin h2 = 1'b1; f2 = mq[i].d; end
      end
      chk("m_aready", AReady, ear);
      chk("m_bready", BReady, ebr);
      chk("m_we", We, mq.size() > 0);
      if (mq.size() > 0) begin
         chk("m_a3", A3, mq[0].a);
         chk("m_wd", Wd, mq[0].d);
      end else begin
         chk("m_a3_idle", A3, 0);
         chk("m_wd_idle", Wd, 0);
      end
      chk("m_count", Count, mq.size());
      chk("m_empty", Empty, mq.size() == 0);
      chk("m_full", Full, mq.size() == 4);
      chk("m_hit1", Hit1, h1);
      chk("m_fd1", Fd1, f1);
      chk("m_hit2", Hit2, h2);
      chk("m_fd2", Fd2, f2);
      @(posedge Clk);
      if (rst) mq.delete();
      else begin
         if (mq.size() > 0) void'(mq.pop_front());
         if (av && ear && aa != 0) mq.push_back({aa, ad});
         if (bv && ebr && ba != 0) mq.push_back({ba, bd});
      end
      #1;
   endtask

   initial begin
      // Single write, dual accept with forwarding, zero register, backpressure and retry.
      tbl[0]  = '{1, 5, 32'h1234, 0, 0, 0,      0, 0, 0, 0,          0, 1, 1, 0, 0};
      tbl[1]  = '{0, 0, 0,        0, 0, 0,      5, 1, 5, 32'h1234,   1, 1, 1, 1, 32'h1234};
      tbl[2]  = '{0, 0, 0,        0, 0, 0,      5, 0, 0, 0,          0, 1, 1, 0, 0};
      tbl[3]  = '{1, 3, 32'hA,    1, 3, 32'hB,  3, 0, 0, 0,          0, 1, 1, 0, 0};
      tbl[4]  = '{0, 0, 0,        0, 0, 0,      3, 1, 3, 32'hA,      2, 1, 1, 1, 32'hB};
      tbl[5]  = '{0, 0, 0,        0, 0, 0,      3, 1, 3, 32'hB,      1, 1, 1, 1, 32'hB};
      tbl[6]  = '{0, 0, 0,        0, 0, 0,      3, 0, 0, 0,          0, 1, 1, 0, 0};
      tbl[7]  = '{1, 0, 32'hFFFF, 0, 0, 0,      0, 0, 0, 0,          0, 1, 1, 0, 0};
      tbl[8]  = '{0, 0, 0,        0, 0, 0,      0, 0, 0, 0,          0, 1, 1, 0, 0};
      tbl[9]  = '{1, 1, 1,        1, 2, 2,      0, 0, 0, 0,          0, 1, 1, 0, 0};
      tbl[10] = '{1, 3, 3,        1, 4, 4,      0, 1, 1, 1,          2, 1, 1, 0, 0};
      tbl[11] = '{1, 5, 5,        1, 6, 6,      0, 1, 2, 2,          3, 1, 0, 0, 0};
      tbl[12] = '{0, 0, 0,        1, 6, 6,      0, 1, 3, 3,          3, 1, 1, 0, 0};
      tbl[13] = '{0, 0, 0,        0, 0, 0,      0, 1, 4, 4,          3, 1, 1, 0, 0};
      tbl[14] = '{0, 0, 0,        0, 0, 0,      0, 1, 5, 5,          2, 1, 1, 0, 0};
      tbl[15] = '{0, 0, 0,        0, 0, 0,      0, 1, 6, 6,          1, 1, 1, 0, 0};
      tbl[16] = '{0, 0, 0,        0, 0, 0,      0, 0, 0, 0,          0, 1, 1, 0, 0};

      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge Clk);
      #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge Clk);
      chk("rst_we", We, 0);      chk("rst_a3", A3, 0);     chk("rst_wd", Wd, 0);
      chk("rst_empty", Empty, 1); chk("rst_full", Full, 0); chk("rst_count", Count, 0);
      chk("rst_hit1", Hit1, 0);  chk("rst_hit2", Hit2, 0);
      chk("rst_aready", AReady, 1); chk("rst_bready", BReady, 1);
      @(posedge Clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         drive(0, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd, tbl[i].q1, 0);
         @(negedge Clk);
         chk($sformatf("v%0d_we", i), We, tbl[i].we);
         chk($sformatf("v%0d_a3", i), A3, tbl[i].a3);
         chk($sformatf("v%0d_wd", i), Wd, tbl[i].wd);
         chk($sformatf("v%0d_count", i), Count, tbl[i].cnt);
         chk($sformatf("v%0d_empty", i), Empty, tbl[i].cnt == 0);
         chk($sformatf("v%0d_full", i), Full, 0);
         chk($sformatf("v%0d_aready", i), AReady, tbl[i].ar);
         chk($sformatf("v%0d_bready", i), BReady, tbl[i].br);
         chk($sformatf("v%0d_hit1", i), Hit1, tbl[i].h1);
         chk($sformatf("v%0d_fd1", i), Fd1, tbl[i].f1);
         chk($sformatf("v%0d_hit2", i), Hit2, 0);
         @(posedge Clk);
         #1;
      end

      // Wrap-around: ten back-to-back single writes keep occupancy at one.
      for (int i = 1; i <= 10; i++) begin
         cyc(0, 1, 5'(i), 32'(i) * 32'h11, 0, 0, 0, 5'(i), 5'(i - 1));
         chk("wrap_cnt_le1", Count <= 3'd1, 1);
      end
      repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset mid-operation with pending entries and live requests.
      cyc(0, 1, 7, 32'h7, 1, 8, 32'h8, 7, 8);
      cyc(0, 1, 9, 32'h9, 1, 10, 32'hA, 9, 8);
      cyc(1, 1, 11, 32'hB, 1, 12, 32'hC, 9, 10);
      cyc(0, 0, 0, 0, 0, 0, 0, 9, 10);
      cyc(0, 0, 0, 0, 0, 0, 0, 11, 12);

      // Random mixed traffic with small address space for duplicates, zero writes and hits.
      for (int i = 0; i < 400; i++) begin
         cyc(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      repeat (5) cyc(0, 0, 0, 0, 0, 0, 0, 1, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
